// File: rtl/ring_pkg.sv
// Shared definitions for the one-hot ring counter and its phase monitor.
package ring_pkg;

  localparam int unsigned RING_W         = 4;
  localparam int unsigned SYNC_N_DEFAULT = 2;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKING  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  typedef enum logic [1:0] {
    S_UNLOCKED = ST_UNLOCKED,
    S_LOCKING  = ST_LOCKING,
    S_LOCKED   = ST_LOCKED
  } mon_state_e;

  // One left-rotation of a ring-width phase vector (MSB wraps to bit 0).
  function automatic logic [RING_W-1:0] rotl(input logic [RING_W-1:0] v);
    return {v[RING_W-2:0], v[RING_W-1]};
  endfunction

endpackage

// File: rtl/ring_phase_monitor_onehot_to_bin.sv
// Combinational one-hot legality check and binary index encoder.
module onehot_to_bin #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             valid_c,
  output logic [IDX_W-1:0] idx_c
);

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  always_comb begin
    valid_c = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
  end

  // OR of set-bit positions; only meaningful when valid_c is high.
  always_comb begin
    idx_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx_c = idx_c | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring phase for legal single-step rotation, reports index,
// rotation count and sticky error flags; ties its pad output enables low.
module ring_phase_monitor
  import ring_pkg::*;
#(
  parameter  int unsigned WIDTH  = RING_W,
  parameter  int unsigned ROT_W  = 8,
  parameter  int unsigned SYNC_N = SYNC_N_DEFAULT,
  localparam int unsigned IDX_W  = $clog2(WIDTH),
  localparam int unsigned OEB_W  = IDX_W + ROT_W + 3
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Phase_in,
  input  logic             Enable,
  input  logic             Clear_err,
  output logic [IDX_W-1:0] Phase_idx,
  output logic [ROT_W-1:0] Rot_count,
  output logic             Locked,
  output logic             Err_onehot,
  output logic             Err_seq,
  output logic [OEB_W-1:0] io_oeb
);

  localparam int unsigned CNT_W = $clog2(SYNC_N + 1);

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic             have_prev_q, have_prev_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ROT_W-1:0] rot_q, rot_d;
  logic             locked_q, locked_d;
  logic             err_oh_q, err_oh_d;
  logic             err_seq_q, err_seq_d;

  logic             valid_c;
  logic [IDX_W-1:0] idx_c;
  logic             step_ok_c;
  logic [CNT_W-1:0] good_inc_c;

  onehot_to_bin #(.WIDTH(WIDTH)) u_onehot_to_bin (
    .vec     (Phase_in),
    .valid_c (valid_c),
    .idx_c   (idx_c)
  );

  always_comb begin
    step_ok_c  = valid_c && have_prev_q &&
                 (Phase_in == {phase_q[WIDTH-2:0], phase_q[WIDTH-1]});
    good_inc_c = good_q + CNT_W'(1);
  end

  // Next-state: clear is applied first so a same-edge error or wrap wins.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    have_prev_d = have_prev_q;
    good_d      = good_q;
    idx_d       = idx_q;
    rot_d       = rot_q;
    err_oh_d    = err_oh_q;
    err_seq_d   = err_seq_q;

    if (Clear_err) begin
      err_oh_d  = 1'b0;
      err_seq_d = 1'b0;
      rot_d     = '0;
    end

    if (!Enable) begin
      state_d     = S_UNLOCKED;
      have_prev_d = 1'b0;
      good_d      = '0;
    end else begin
      phase_d     = Phase_in;
      have_prev_d = 1'b1;
      if (valid_c) begin
        idx_d = idx_c;
      end
      case (state_q)
        S_UNLOCKED: begin
          if (valid_c) begin
            state_d = S_LOCKING;
            good_d  = '0;
          end
        end
        S_LOCKING: begin
          if (step_ok_c) begin
            good_d = good_inc_c;
            if (good_inc_c == CNT_W'(SYNC_N)) begin
              state_d = S_LOCKED;
            end
          end else if (valid_c) begin
            good_d = '0;
          end else begin
            state_d = S_UNLOCKED;
          end
        end
        S_LOCKED: begin
          if (step_ok_c) begin
            if (Phase_in[0]) begin
              rot_d = rot_d + ROT_W'(1);
            end
          end else if (!valid_c) begin
            err_oh_d = 1'b1;
            state_d  = S_UNLOCKED;
          end else begin
            err_seq_d = 1'b1;
            state_d   = S_LOCKING;
            good_d    = '0;
          end
        end
        default: begin
          state_d = S_UNLOCKED;
          good_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_UNLOCKED;
      phase_q     <= '0;
      have_prev_q <= 1'b0;
      good_q      <= '0;
      idx_q       <= '0;
      rot_q       <= '0;
      locked_q    <= 1'b0;
      err_oh_q    <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      have_prev_q <= have_prev_d;
      good_q      <= good_d;
      idx_q       <= idx_d;
      rot_q       <= rot_d;
      locked_q    <= locked_d;
      err_oh_q    <= err_oh_d;
      err_seq_q   <= err_seq_d;
    end
  end

  assign Phase_idx  = idx_q;
  assign Rot_count  = rot_q;
  assign Locked     = locked_q;
  assign Err_onehot = err_oh_q;
  assign Err_seq    = err_seq_q;
  assign io_oeb     = '0;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed self-checking bench for ring_phase_monitor (WIDTH=4, ROT_W=8, SYNC_N=2).
module tb_ring_phase_monitor;

  logic       Clock;
  logic       Reset;
  logic [3:0] Phase_in;
  logic       Enable;
  logic       Clear_err;
  logic [1:0] Phase_idx;
  logic [7:0] Rot_count;
  logic       Locked;
  logic       Err_onehot;
  logic       Err_seq;
  logic [12:0] io_oeb;

  int checks = 0;
  int errors = 0;

  ring_phase_monitor #(.WIDTH(4), .ROT_W(8), .SYNC_N(2)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Phase_in   (Phase_in),
    .Enable     (Enable),
    .Clear_err  (Clear_err),
    .Phase_idx  (Phase_idx),
    .Rot_count  (Rot_count),
    .Locked     (Locked),
    .Err_onehot (Err_onehot),
    .Err_seq    (Err_seq),
    .io_oeb     (io_oeb)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] idx, input logic [7:0] rot,
                         input logic lk, input logic eo, input logic es);
    chk({tag, "_idx"},    32'(Phase_idx),  32'(idx));
    chk({tag, "_rot"},    32'(Rot_count),  32'(rot));
    chk({tag, "_locked"}, 32'(Locked),     32'(lk));
    chk({tag, "_erroh"},  32'(Err_onehot), 32'(eo));
    chk({tag, "_errseq"}, 32'(Err_seq),    32'(es));
    chk({tag, "_oeb"},    32'(io_oeb),     32'(0));
  endtask

  // Apply inputs, take one rising edge, settle just after it.
  task automatic tick(input logic [3:0] ph, input logic en, input logic clr);
    Phase_in  = ph;
    Enable    = en;
    Clear_err = clr;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Clock     = 1'b0;
    Reset     = 1'b1;
    Phase_in  = 4'b0000;
    Enable    = 1'b0;
    Clear_err = 1'b0;

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    chk_all("reset", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;

    // Lock-up and first rotation
    tick(4'b0001, 1'b1, 1'b0); chk_all("e1", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick(4'b0010, 1'b1, 1'b0); chk_all("e2", 2'd1, 8'd0, 1'b0, 1'b0, 1'b0);
    tick(4'b0100, 1'b1, 1'b0); chk_all("e3", 2'd2, 8'd0, 1'b1, 1'b0, 1'b0);
    tick(4'b1000, 1'b1, 1'b0); chk_all("e4", 2'd3, 8'd0, 1'b1, 1'b0, 1'b0);
    tick(4'b0001, 1'b1, 1'b0); chk_all("e5", 2'd0, 8'd1, 1'b1, 1'b0, 1'b0);

    // Non-one-hot while locked, then relock; flag sticks until cleared
    tick(4'b0110, 1'b1, 1'b0); chk_all("bad_oh",  2'd0, 8'd1, 1'b0, 1'b1, 1'b0);
    tick(4'b0001, 1'b1, 1'b0); chk_all("rl1",     2'd0, 8'd1, 1'b0, 1'b1, 1'b0);
    tick(4'b0010, 1'b1, 1'b0); chk_all("rl2",     2'd1, 8'd1, 1'b0, 1'b1, 1'b0);
    tick(4'b0100, 1'b1, 1'b0); chk_all("rl3",     2'd2, 8'd1, 1'b1, 1'b1, 1'b0);
    tick(4'b1000, 1'b1, 1'b0); chk_all("rl4",     2'd3, 8'd1, 1'b1, 1'b1, 1'b0);
    tick(4'b0001, 1'b1, 1'b0); chk_all("rl5",     2'd0, 8'd2, 1'b1, 1'b1, 1'b0);
    tick(4'b0010, 1'b1, 1'b1); chk_all("clr1",    2'd1, 8'd0, 1'b1, 1'b0, 1'b0);
    tick(4'b0100, 1'b1, 1'b0);
    tick(4'b1000, 1'b1, 1'b0);
    tick(4'b0001, 1'b1, 1'b0); chk_all("rot_a",   2'd0, 8'd1, 1'b1, 1'b0, 1'b0);
    tick(4'b0010, 1'b1, 1'b0); chk_all("at0010",  2'd1, 8'd1, 1'b1, 1'b0, 1'b0);

    // Skipped phase while locked
    tick(4'b1000, 1'b1, 1'b0); chk_all("skip",    2'd3, 8'd1, 1'b0, 1'b0, 1'b1);
    tick(4'b0001, 1'b1, 1'b0); chk_all("sk_rl1",  2'd0, 8'd1, 1'b0, 1'b0, 1'b1);
    tick(4'b0010, 1'b1, 1'b0); chk_all("sk_rl2",  2'd1, 8'd1, 1'b1, 1'b0, 1'b1);
    tick(4'b0100, 1'b1, 1'b1); chk_all("clr2",    2'd2, 8'd0, 1'b1, 1'b0, 1'b0);

    // 255 rotations, then the wrap to 0, then clear coinciding with a wrap
    for (int r = 1; r <= 255; r++) begin
      tick(4'b1000, 1'b1, 1'b0);
      tick(4'b0001, 1'b1, 1'b0);
      tick(4'b0010, 1'b1, 1'b0);
      tick(4'b0100, 1'b1, 1'b0);
    end
    chk_all("rot255", 2'd2, 8'd255, 1'b1, 1'b0, 1'b0);
    tick(4'b1000, 1'b1, 1'b0);
    tick(4'b0001, 1'b1, 1'b0); chk_all("wrap0",   2'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    tick(4'b0010, 1'b1, 1'b0);
    tick(4'b0100, 1'b1, 1'b0);
    tick(4'b1000, 1'b1, 1'b0);
    tick(4'b0001, 1'b1, 1'b1); chk_all("clrwrap", 2'd0, 8'd1, 1'b1, 1'b0, 1'b0);

    // Enable gap: hold values, unlock, fresh relock on re-enable
    tick(4'b0010, 1'b0, 1'b0); chk_all("gap1",    2'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0); chk_all("gap2",    2'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(4'b1000, 1'b0, 1'b0); chk_all("gap3",    2'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(4'b0010, 1'b1, 1'b0); chk_all("ren1",    2'd1, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(4'b0100, 1'b1, 1'b0); chk_all("ren2",    2'd2, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(4'b1000, 1'b1, 1'b0); chk_all("ren3",    2'd3, 8'd1, 1'b1, 1'b0, 1'b0);
    tick(4'b0001, 1'b1, 1'b0); chk_all("ren4",    2'd0, 8'd2, 1'b1, 1'b0, 1'b0);

    // Error flags set, then asynchronous reset between edges clears all
    tick(4'b0100, 1'b1, 1'b0); chk_all("pre_rst", 2'd2, 8'd2, 1'b0, 1'b0, 1'b1);
    #3;
    Reset = 1'b1;
    #1;
    chk_all("async_rst", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge Clock);
    #1;
    chk_all("rst_hold", 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
